// File: rtl/lsu_mem_initiator.sv
// Load/store initiator: checks alignment and RAM window, drives one RAM strobe
// cycle per good request, extends load data and returns a handshaked response.
//   state | meaning
//   IDLE  | ready for a request
//   ISSUE | RAM strobe (read or write) high this cycle
//   RWAIT | counting down the RAM read latency
//   RESP  | response held until resp_ready
module lsu_mem_initiator #(
  parameter logic [63:0] RAM_BASE   = 64'h8000_0000,
  parameter int          RAM_BYTES  = 1024,
  parameter int          RD_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [1:0]  req_wdt,
  input  logic        req_sext,
  output logic        mem_ren,
  output logic [63:0] mem_raddr,
  output logic        mem_wen,
  output logic [63:0] mem_waddr,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_wmask,
  input  logic [63:0] mem_rdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic [1:0]  resp_err
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] RWAIT = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;
  localparam logic [64:0] WIN_END  = {1'b0, RAM_BASE} + 65'(RAM_BYTES);
  localparam logic [1:0]  CNT_INIT = 2'(RD_LATENCY - 1);

  logic [1:0]  state;
  logic [1:0]  cnt;
  logic [1:0]  wdt_q;
  logic [2:0]  lane_q;
  logic        wen_q;
  logic        sext_q;

  logic [3:0]  nbytes;
  logic [7:0]  base_mask;
  logic        misaligned;
  logic        out_of_window;
  logic [64:0] req_end;
  logic [63:0] lane_data;
  logic [63:0] load_ext;

  assign req_ready = (state == IDLE);
  assign nbytes    = 4'd1 << req_wdt;
  // 65-bit end address so requests near 2^64 cannot wrap into the window
  assign req_end   = {1'b0, req_addr} + {61'd0, nbytes};
  assign out_of_window = (req_addr < RAM_BASE) || (req_end > WIN_END);
  assign lane_data = mem_rdata >> {lane_q, 3'b000};

  always_comb begin
    base_mask  = 8'h01;
    misaligned = 1'b0;
    case (req_wdt)
      2'b00: begin base_mask = 8'h01; misaligned = 1'b0;             end
      2'b01: begin base_mask = 8'h03; misaligned = req_addr[0];      end
      2'b10: begin base_mask = 8'h0F; misaligned = |req_addr[1:0];   end
      default: begin base_mask = 8'hFF; misaligned = |req_addr[2:0]; end
    endcase
  end

  always_comb begin
    load_ext = lane_data;
    case (wdt_q)
      2'b00: load_ext = sext_q ? {{56{lane_data[7]}},  lane_data[7:0]}  : {56'd0, lane_data[7:0]};
      2'b01: load_ext = sext_q ? {{48{lane_data[15]}}, lane_data[15:0]} : {48'd0, lane_data[15:0]};
      2'b10: load_ext = sext_q ? {{32{lane_data[31]}}, lane_data[31:0]} : {32'd0, lane_data[31:0]};
      default: load_ext = lane_data;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= 2'd0;
      wdt_q      <= 2'd0;
      lane_q     <= 3'd0;
      wen_q      <= 1'b0;
      sext_q     <= 1'b0;
      mem_ren    <= 1'b0;
      mem_raddr  <= 64'd0;
      mem_wen    <= 1'b0;
      mem_waddr  <= 64'd0;
      mem_wdata  <= 64'd0;
      mem_wmask  <= 8'd0;
      resp_valid <= 1'b0;
      resp_rdata <= 64'd0;
      resp_err   <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            wdt_q  <= req_wdt;
            lane_q <= req_addr[2:0];
            wen_q  <= req_wen;
            sext_q <= req_sext;
            if (misaligned || out_of_window) begin
              resp_valid <= 1'b1;
              resp_rdata <= 64'd0;
              resp_err   <= misaligned ? 2'b01 : 2'b10;
              state      <= RESP;
            end else begin
              if (req_wen) begin
                mem_wen   <= 1'b1;
                mem_waddr <= {req_addr[63:3], 3'b000};
                mem_wmask <= base_mask << req_addr[2:0];
                mem_wdata <= req_wdata << {req_addr[2:0], 3'b000};
              end else begin
                mem_ren   <= 1'b1;
                mem_raddr <= {req_addr[63:3], 3'b000};
              end
              state <= ISSUE;
            end
          end
        end
        ISSUE: begin
          mem_ren   <= 1'b0;
          mem_raddr <= 64'd0;
          mem_wen   <= 1'b0;
          mem_waddr <= 64'd0;
          mem_wdata <= 64'd0;
          mem_wmask <= 8'd0;
          if (wen_q) begin
            resp_valid <= 1'b1;
            resp_rdata <= 64'd0;
            resp_err   <= 2'b00;
            state      <= RESP;
          end else begin
            cnt   <= CNT_INIT;
            state <= RWAIT;
          end
        end
        RWAIT: begin
          if (cnt == 2'd0) begin
            resp_valid <= 1'b1;
            resp_rdata <= load_ext;
            resp_err   <= 2'b00;
            state      <= RESP;
          end else begin
            cnt <= cnt - 2'd1;
          end
        end
        default: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            resp_rdata <= 64'd0;
            resp_err   <= 2'b00;
            state      <= IDLE;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Bench for lsu_mem_initiator: byte-array reference memory, latency-pipelined
// RAM model, directed corner cases followed by random requests.
module tb_lsu_mem_initiator;
  localparam logic [63:0] BASE  = 64'h8000_0000;
  localparam int          BYTES = 1024;
  localparam int          LAT   = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_wen, req_sext;
  logic [63:0] req_addr, req_wdata;
  logic [1:0]  req_wdt;
  logic        mem_ren, mem_wen;
  logic [63:0] mem_raddr, mem_waddr, mem_wdata, mem_rdata;
  logic [7:0]  mem_wmask;
  logic        resp_valid, resp_ready;
  logic [63:0] resp_rdata;
  logic [1:0]  resp_err;

  int tests = 0;
  int fails = 0;
  logic        init_done;
  logic [7:0]  ref_mem [BYTES];
  logic [63:0] ram [BYTES/8];
  logic [63:0] rpipe [LAT];

  lsu_mem_initiator #(.RAM_BASE(BASE), .RAM_BYTES(BYTES), .RD_LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wdt(req_wdt), .req_sext(req_sext),
    .mem_ren(mem_ren), .mem_raddr(mem_raddr), .mem_wen(mem_wen), .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rdata(mem_rdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] pat(input int w);
    return 64'h9E37_79B9_7F4A_7C15 * 64'(w + 1);
  endfunction

  // RAM model: read data appears LAT cycles after the mem_ren cycle, garbage otherwise
  always @(posedge clk) begin
    if (!init_done) begin
      for (int w = 0; w < BYTES/8; w++) ram[w] <= pat(w);
    end else if (mem_wen) begin
      for (int b = 0; b < 8; b++)
        if (mem_wmask[b]) ram[mem_waddr[9:3]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
    rpipe[0] <= mem_ren ? ram[mem_raddr[9:3]] : {$urandom, $urandom};
    for (int i = 1; i < LAT; i++) rpipe[i] <= rpipe[i-1];
  end
  assign mem_rdata = rpipe[LAT-1];

  function automatic void chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endfunction

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".req_ready"}, 64'(req_ready), 64'd1);
    chk({tag, ".ctl"}, 64'({mem_ren, mem_wen, mem_wmask, resp_valid, resp_err}), 64'd0);
    chk({tag, ".raddr"}, mem_raddr, 64'd0);
    chk({tag, ".waddr"}, mem_waddr, 64'd0);
    chk({tag, ".wdata"}, mem_wdata, 64'd0);
    chk({tag, ".rdata"}, resp_rdata, 64'd0);
  endtask

  // One request end to end; called at a negedge with the DUT idle.
  task automatic run_req(input string tag, input logic w, input logic [63:0] a,
                         input logic [63:0] d, input logic [1:0] t, input logic s, input int hold);
    int n, off, cyc, exp_lat, ren_seen, wen_seen;
    bit done;
    logic [1:0]  exp_err;
    logic [63:0] exp_rd, exp_wd, bmask, snap;
    logic [7:0]  exp_mask;
    n = 1 << t;
    if ((a % 64'(n)) != 0) exp_err = 2'b01;
    else if ((a < BASE) || ({1'b0, a} + 65'(n) > {1'b0, BASE} + 65'(BYTES))) exp_err = 2'b10;
    else exp_err = 2'b00;
    exp_rd = 64'd0;
    off = int'(a - BASE);
    if (exp_err == 2'b00 && !w) begin
      for (int i = 0; i < n; i++) exp_rd[8*i +: 8] = ref_mem[off + i];
      if (s && n < 8 && exp_rd[8*n-1]) exp_rd = exp_rd | (~64'd0 << (8*n));
    end
    if (exp_err == 2'b00 && w)
      for (int i = 0; i < n; i++) ref_mem[off + i] = d[8*i +: 8];
    exp_lat  = (exp_err != 2'b00) ? 1 : (w ? 2 : LAT + 2);
    exp_mask = 8'(((1 << n) - 1) << a[2:0]);
    exp_wd   = d << (8 * a[2:0]);
    for (int b = 0; b < 8; b++) bmask[8*b +: 8] = {8{exp_mask[b]}};

    resp_ready = (hold == 0);
    req_valid = 1'b1; req_wen = w; req_addr = a; req_wdata = d; req_wdt = t; req_sext = s;
    chk({tag, ".req_ready"}, 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    req_valid = 1'b0; req_wen = 1'($urandom); req_addr = {$urandom, $urandom};
    req_wdata = {$urandom, $urandom}; req_wdt = 2'($urandom); req_sext = 1'($urandom);

    cyc = 0; ren_seen = 0; wen_seen = 0; done = 0;
    while (!done && cyc < 20) begin
      @(negedge clk); cyc++;
      chk({tag, ".both_strobes"}, 64'(mem_ren & mem_wen), 64'd0);
      if (mem_ren) begin
        ren_seen++;
        chk({tag, ".raddr"}, mem_raddr, {a[63:3], 3'b000});
      end
      if (mem_wen) begin
        wen_seen++;
        chk({tag, ".waddr"}, mem_waddr, {a[63:3], 3'b000});
        chk({tag, ".wmask"}, 64'(mem_wmask), 64'(exp_mask));
        chk({tag, ".wdata"}, mem_wdata & bmask, exp_wd & bmask);
      end
      if (resp_valid) done = 1;
    end
    chk({tag, ".latency"}, 64'(cyc), 64'(exp_lat));
    chk({tag, ".ren_cycles"}, 64'(ren_seen), 64'((exp_err == 2'b00 && !w) ? 1 : 0));
    chk({tag, ".wen_cycles"}, 64'(wen_seen), 64'((exp_err == 2'b00 && w) ? 1 : 0));
    chk({tag, ".err"}, 64'(resp_err), 64'(exp_err));
    chk({tag, ".rdata"}, resp_rdata, exp_rd);
    chk({tag, ".busy"}, 64'(req_ready), 64'd0);
    snap = resp_rdata;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({tag, ".hold_valid"}, 64'(resp_valid), 64'd1);
      chk({tag, ".hold_rdata"}, resp_rdata, snap);
      chk({tag, ".hold_busy"}, 64'(req_ready), 64'd0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    chk({tag, ".done_valid"}, 64'(resp_valid), 64'd0);
    chk({tag, ".done_ready"}, 64'(req_ready), 64'd1);
  endtask

  initial begin
    logic [63:0] word, a, d;
    logic [1:0]  t;
    int sel;
    rst_n = 1'b0; init_done = 1'b0;
    req_valid = 1'b0; req_wen = 1'b0; req_addr = 64'd0; req_wdata = 64'd0;
    req_wdt = 2'b00; req_sext = 1'b0; resp_ready = 1'b1;
    for (int i = 0; i < BYTES; i++) begin
      word = pat(i / 8);
      ref_mem[i] = word[8*(i % 8) +: 8];
    end
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    init_done = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);

    run_req("st_byte",   1'b1, 64'h8000_0005, 64'hAB, 2'b00, 1'b0, 0);
    run_req("st_dword",  1'b1, 64'h8000_0008, 64'h8765_4321_0000_0000, 2'b11, 1'b0, 0);
    run_req("ld_w_sext", 1'b0, 64'h8000_000C, 64'd0, 2'b10, 1'b1, 0);
    chk("ld_w_sext.direct", resp_rdata, 64'd0);
    run_req("ld_w_zext", 1'b0, 64'h8000_000C, 64'd0, 2'b10, 1'b0, 0);
    run_req("ld_b_back", 1'b0, 64'h8000_0005, 64'd0, 2'b00, 1'b0, 0);
    run_req("mis_ld_h",  1'b0, 64'h8000_0003, 64'd0, 2'b01, 1'b0, 0);
    run_req("mis_st_d",  1'b1, 64'h8000_0004, 64'h1234, 2'b11, 1'b0, 0);
    run_req("win_lo",    1'b0, 64'h7FFF_FFFF, 64'd0, 2'b00, 1'b0, 0);
    run_req("win_mis",   1'b1, BASE + 64'(BYTES) - 64'd2, 64'h55, 2'b10, 1'b0, 0);
    run_req("win_top",   1'b0, BASE + 64'(BYTES) - 64'd8, 64'd0, 2'b11, 1'b0, 0);
    run_req("win_over",  1'b0, BASE + 64'(BYTES), 64'd0, 2'b00, 1'b0, 0);
    run_req("win_wrap",  1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 64'd0, 2'b11, 1'b0, 0);
    run_req("bp_load",   1'b0, 64'h8000_0010, 64'd0, 2'b11, 1'b0, 5);
    run_req("b2b_ld",    1'b0, 64'h8000_0020, 64'd0, 2'b01, 1'b1, 0);
    run_req("b2b_st",    1'b1, 64'h8000_0022, 64'hBEEF, 2'b01, 1'b0, 0);

    for (int k = 0; k < 40; k++) begin
      t = 2'($urandom);
      sel = int'($urandom_range(0, 9));
      if (sel == 0)      a = BASE - 64'd8 + 64'($urandom_range(0, 15));
      else if (sel == 1) a = BASE + 64'(BYTES) - 64'd8 + 64'($urandom_range(0, 15));
      else if (sel == 2) a = 64'hFFFF_FFFF_FFFF_FFF8 + 64'($urandom_range(0, 7));
      else               a = BASE + 64'($urandom_range(0, BYTES - 1));
      if ($urandom_range(0, 3) != 0) a = a & ~64'((1 << t) - 1);
      d = {$urandom, $urandom};
      run_req($sformatf("rnd%0d", k), 1'($urandom), a, d, t, 1'($urandom),
              int'($urandom_range(0, 3)));
    end

    // Reset in the middle of a load's read wait
    resp_ready = 1'b1;
    req_valid = 1'b1; req_wen = 1'b0; req_addr = 64'h8000_0040; req_wdt = 2'b11; req_sext = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b0; #1;
    chk_reset_outputs("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("rst_after.valid", 64'(resp_valid), 64'd0);
      chk("rst_after.strobes", 64'({mem_ren, mem_wen}), 64'd0);
      chk("rst_after.ready", 64'(req_ready), 64'd1);
    end
    run_req("post_rst_ld", 1'b0, 64'h8000_000C, 64'd0, 2'b10, 1'b1, 0);
    run_req("post_rst_st", 1'b1, 64'h8000_0041, 64'h7F, 2'b00, 1'b0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
